mel_status_serializer: RTL

//  Serial transmitter feeding the MEL status receiver's two-wire link (sync on MEL_XTRA[1], data on MEL_XTRA[2]).
//  - Accepts a 16-bit status word: bits [6:4] carry the MEL control state (0 HOME, 1 MEL_OPEN, 2 ACK, 3 NOACK, 4 ENABLE_OFF).
//  - Shifts the word out LSB first, one bit per SYSCLK, then pulses sync so the receiver latches the whole word.
//  - Optional auto-repeat refreshes the receiver continuously with the held word.

---
 rtl/mel_status_serializer.sv | 95 +++++++++
 1 files changed

// File: rtl/mel_status_serializer.sv
// Serial transmitter for the MEL status receiver link: shifts a status word out LSB first,
// then pulses sync so the receiver latches it. Optional auto-repeat resends the held word.
module mel_status_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  SYSCLK,
    input  logic                  OPB_RST,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  DATA_VALID,
    output logic                  DATA_READY,
    input  logic                  AUTO_REPEAT,
    output logic                  SERIAL_D,
    output logic                  SERIAL_SYNC,
    output logic                  BUSY,
    output logic [15:0]           FRAME_CNT
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, SYNC, GAP} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] held;
    logic                  have_word;
    logic [CW-1:0]         bit_cnt;
    logic [7:0]            gap_cnt;
    logic                  take_new;
    logic                  start;
    logic [DATA_WIDTH-1:0] load_word;

    // A fresh word always wins over a repeat of the held one.
    assign take_new  = DATA_VALID && DATA_READY;
    assign start     = take_new || (AUTO_REPEAT && have_word);
    assign load_word = take_new ? DATA_IN : held;

    always_ff @(posedge SYSCLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state       <= IDLE;
            held        <= '0;
            have_word   <= 1'b0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            SERIAL_D    <= 1'b0;
            SERIAL_SYNC <= 1'b0;
            DATA_READY  <= 1'b1;
            BUSY        <= 1'b0;
            FRAME_CNT   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        held       <= load_word;
                        have_word  <= 1'b1;
                        SERIAL_D   <= load_word[0];
                        bit_cnt    <= '0;
                        state      <= SHIFT;
                        DATA_READY <= 1'b0;
                        BUSY       <= 1'b1;
                    end else begin
                        SERIAL_D <= 1'b0;
                    end
                end
                SHIFT: begin
                    // The last bit is held one extra cycle so the sync edge lands after its sample.
                    if (bit_cnt == LAST_BIT) begin
                        state       <= SYNC;
                        SERIAL_SYNC <= 1'b1;
                        FRAME_CNT   <= FRAME_CNT + 16'd1;
                    end else begin
                        bit_cnt  <= bit_cnt + 1'b1;
                        SERIAL_D <= held[bit_cnt + 1'b1];
                    end
                end
                SYNC: begin
                    state       <= GAP;
                    SERIAL_SYNC <= 1'b0;
                    SERIAL_D    <= 1'b0;
                    gap_cnt     <= '0;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state      <= IDLE;
                        DATA_READY <= 1'b1;
                        BUSY       <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
